// File: rtl/colour_map_pipe_if.sv
// Beat interface for the colour mapper: phase/mag/mode in, RGB out, valid/ready on both sides.
// slave = mapper view, master = producer/consumer view.
interface colour_map_pipe_if #(
  parameter int PH_W  = 8,
  parameter int MAG_W = 8,
  parameter int COL_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [PH_W-1:0]  phase;
  logic [MAG_W-1:0] mag;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [COL_W-1:0] red;
  logic [COL_W-1:0] green;
  logic [COL_W-1:0] blue;

  modport slave (
    input  in_valid, phase, mag, mode, out_ready,
    output in_ready, out_valid, red, green, blue
  );

  modport master (
    output in_valid, phase, mag, mode, out_ready,
    input  in_ready, out_valid, red, green, blue
  );
endinterface

// File: rtl/colour_map_pipe.sv
// Phase/magnitude -> RGB hue-wheel mapper, 3-stage pipeline (3 advancing cycles, 1 beat/cycle).
// Whole pipe advances only when the output slot is empty or being taken; otherwise every stage holds.
module colour_map_pipe #(
  parameter int PH_W       = 8,
  parameter int MAG_W      = 8,
  parameter int COL_W      = 8,
  parameter int SAT_THRESH = 240
) (
  input logic              clk,
  input logic              reset,
  colour_map_pipe_if.slave bus
);
  typedef struct packed {
    logic [COL_W-1:0] r;
    logic [COL_W-1:0] g;
    logic [COL_W-1:0] b;
  } rgb_t;

  localparam logic [COL_W-1:0] MAX     = '1;
  localparam logic [COL_W-1:0] ZERO    = '0;
  localparam logic [MAG_W-1:0] B_FULL  = '1;
  localparam logic [MAG_W-1:0] SAT_LVL = MAG_W'(SAT_THRESH);
  localparam logic [PH_W-1:0]  HALF    = {1'b1, {(PH_W-1){1'b0}}};

  // Full-scale brightness bypasses the multiply so MAX stays MAX.
  function automatic logic [COL_W-1:0] scale(input logic [COL_W-1:0] c, input logic [MAG_W-1:0] b);
    logic [COL_W+MAG_W-1:0] p;
    p = {{MAG_W{1'b0}}, c} * {{COL_W{1'b0}}, b};
    scale = (b == B_FULL) ? c : COL_W'(p >> MAG_W);
  endfunction

  logic             adv;
  logic [PH_W-1:0]  hue;
  logic [PH_W+2:0]  p6;
  logic [COL_W-1:0] rise, fall, grey;
  rgb_t             col, scaled;

  logic             s1_vld_q,  s1_vld_d;
  logic [2:0]       s1_sec_q,  s1_sec_d;
  logic [COL_W-1:0] s1_ramp_q, s1_ramp_d;
  logic [MAG_W-1:0] s1_mag_q,  s1_mag_d;
  logic [1:0]       s1_mode_q, s1_mode_d;

  logic             s2_vld_q,  s2_vld_d;
  rgb_t             s2_col_q,  s2_col_d;
  logic [MAG_W-1:0] s2_bri_q,  s2_bri_d;
  logic [1:0]       s2_mode_q, s2_mode_d;
  logic             s2_sat_q,  s2_sat_d;

  logic             out_vld_q, out_vld_d;
  rgb_t             out_col_q, out_col_d;

  always_comb begin
    adv  = !out_vld_q || bus.out_ready;
    hue  = bus.phase + HALF;
    p6   = ({3'b000, hue} << 2) + ({3'b000, hue} << 1);
    rise = s1_ramp_q;
    fall = MAX - s1_ramp_q;
    case (s1_sec_q)
      3'd0:    col = {MAX, rise, ZERO};
      3'd1:    col = {fall, MAX, ZERO};
      3'd2:    col = {ZERO, MAX, rise};
      3'd3:    col = {ZERO, fall, MAX};
      3'd4:    col = {rise, ZERO, MAX};
      3'd5:    col = {MAX, ZERO, fall};
      default: col = {ZERO, ZERO, ZERO};
    endcase
    grey   = s2_bri_q[MAG_W-1 -: COL_W];
    scaled = {scale(s2_col_q.r, s2_bri_q), scale(s2_col_q.g, s2_bri_q), scale(s2_col_q.b, s2_bri_q)};

    s1_vld_d  = s1_vld_q;
    s1_sec_d  = s1_sec_q;
    s1_ramp_d = s1_ramp_q;
    s1_mag_d  = s1_mag_q;
    s1_mode_d = s1_mode_q;
    s2_vld_d  = s2_vld_q;
    s2_col_d  = s2_col_q;
    s2_bri_d  = s2_bri_q;
    s2_mode_d = s2_mode_q;
    s2_sat_d  = s2_sat_q;
    out_vld_d = out_vld_q;
    out_col_d = out_col_q;

    if (adv) begin
      s1_vld_d  = bus.in_valid;
      s1_sec_d  = p6[PH_W+2:PH_W];
      s1_ramp_d = p6[PH_W-1 -: COL_W];
      s1_mag_d  = bus.mag;
      s1_mode_d = bus.mode;

      s2_vld_d  = s1_vld_q;
      s2_col_d  = col;
      s2_bri_d  = s1_mag_q;
      s2_mode_d = s1_mode_q;
      s2_sat_d  = (s1_mode_q == 2'd3) && (s1_mag_q >= SAT_LVL);

      out_vld_d = s2_vld_q;
      case (s2_mode_q)
        2'd1:    out_col_d = s2_col_q;
        2'd2:    out_col_d = {grey, grey, grey};
        default: out_col_d = scaled;
      endcase
      if (s2_sat_q) out_col_d = {MAX, MAX, MAX};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld_q  <= 1'b0;
      s1_sec_q  <= '0;
      s1_ramp_q <= '0;
      s1_mag_q  <= '0;
      s1_mode_q <= '0;
      s2_vld_q  <= 1'b0;
      s2_col_q  <= '0;
      s2_bri_q  <= '0;
      s2_mode_q <= '0;
      s2_sat_q  <= 1'b0;
      out_vld_q <= 1'b0;
      out_col_q <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_sec_q  <= s1_sec_d;
      s1_ramp_q <= s1_ramp_d;
      s1_mag_q  <= s1_mag_d;
      s1_mode_q <= s1_mode_d;
      s2_vld_q  <= s2_vld_d;
      s2_col_q  <= s2_col_d;
      s2_bri_q  <= s2_bri_d;
      s2_mode_q <= s2_mode_d;
      s2_sat_q  <= s2_sat_d;
      out_vld_q <= out_vld_d;
      out_col_q <= out_col_d;
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = out_vld_q;
  assign bus.red       = out_col_q.r;
  assign bus.green     = out_col_q.g;
  assign bus.blue      = out_col_q.b;
endmodule
